// File: rtl/avalon_pio_initiator.sv
// Avalon-MM initiator: one command in flight, turned into a single bus read or write
// with waitrequest handling, fixed read latency and a stall timeout.
//
// state  | meaning
// IDLE   | ready for a command
// WR     | avm_write asserted, waiting for waitrequest low
// RD     | avm_read asserted, waiting for waitrequest low
// RD_LAT | read accepted, counting slave latency before capturing readdata
// RSP    | one-cycle response pulse
module avalon_pio_initiator #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] STALL_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_LAT, RSP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        lat_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout_q;
    logic              accept, lat_done, timed_out, rd_done, to_hit;

    assign accept    = (state == IDLE) && cmd_valid;
    assign lat_done  = (lat_cnt == 2'(READ_LATENCY));
    // Abort at the edge ending the TIMEOUT-th stalled cycle; a release in that cycle wins.
    assign timed_out = TO_EN && avm_waitrequest && (stall_cnt == STALL_LAST);
    assign rd_done   = ((state == RD) && !avm_waitrequest && (READ_LATENCY == 0)) ||
                       ((state == RD_LAT) && lat_done);
    assign to_hit    = ((state == WR) || (state == RD)) && timed_out;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = cmd_write ? WR : RD;
            end
            WR: begin
                if (!avm_waitrequest || timed_out) state_nxt = RSP;
            end
            RD: begin
                if (!avm_waitrequest) state_nxt = (READ_LATENCY == 0) ? RSP : RD_LAT;
                else if (timed_out) state_nxt = RSP;
            end
            RD_LAT: begin
                if (lat_done) state_nxt = RSP;
            end
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            stall_cnt     <= '0;
            lat_cnt       <= 2'd1;
            rdata_q       <= '0;
            timeout_q     <= 1'b0;
        end else begin
            avm_read  <= (state_nxt == RD);
            avm_write <= (state_nxt == WR);
            if (accept) begin
                avm_address   <= cmd_addr;
                avm_writedata <= cmd_wdata;
                rdata_q       <= '0;
                timeout_q     <= 1'b0;
                stall_cnt     <= '0;
            end else if (TO_EN && (avm_read || avm_write) && avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (state != RD_LAT) lat_cnt <= 2'd1;
            else                 lat_cnt <= lat_cnt + 2'd1;
            if (rd_done) rdata_q <= avm_readdata;
            if (to_hit)  timeout_q <= 1'b1;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RSP);
    assign rsp_timeout = rsp_valid && timeout_q;
    assign rsp_rdata   = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_avalon_pio_initiator.sv
// Self-checking bench for avalon_pio_initiator: directed vector table, reset corners,
// and randomized commands checked against a transaction-level expectation model.
module tb_avalon_pio_initiator;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int RL     = 1;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read, avm_write, avm_waitrequest;
    logic [DATA_W-1:0] avm_writedata, avm_readdata;

    int n_cmp = 0;
    int n_bad = 0;

    avalon_pio_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] sdata;
        int          e_stb;
        int          e_delay;
        logic        e_to;
        logic [31:0] e_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected outcome from the protocol rules: stalls beyond TO abort, reads add latency.
    function automatic void model(input logic wr, input int stall, input logic [31:0] sdata,
                                  output int e_stb, output int e_delay, output logic e_to,
                                  output logic [31:0] e_rd);
        e_to    = (stall >= TO);
        e_stb   = e_to ? TO : stall + 1;
        e_delay = (wr || e_to) ? 1 : 1 + RL;
        e_rd    = (wr || e_to) ? 32'h0 : sdata;
    endfunction

    // Issues one command and plays the slave: waitrequest high for the first 'stall'
    // strobe cycles, readdata valid only RL cycles after read acceptance.
    task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                           input int stall, input logic [31:0] sdata, input bit junk,
                           output int nstb, output int delay, output logic to,
                           output logic [31:0] rd, output int bus_err);
        int last_stb;
        int rsp_at;
        int w;
        int i;
        bit prev_acc;
        nstb = 0; delay = -1; to = 1'bx; rd = 'x; bus_err = 0;
        last_stb = 0; rsp_at = -1; prev_acc = 1'b0; w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!cmd_ready) bus_err++;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        i = 0;
        while (rsp_at < 0 && i < 40) begin
            @(posedge clk); #1;
            i++;
            if (junk) begin
                cmd_write = 1'($urandom);
                cmd_addr  = 4'($urandom);
                cmd_wdata = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            avm_readdata = prev_acc ? sdata : $urandom;
            prev_acc = 1'b0;
            if (avm_read && avm_write) bus_err++;
            if (avm_read || avm_write) begin
                if (avm_write !== wr || avm_address !== addr || (wr && avm_writedata !== wd))
                    bus_err++;
                avm_waitrequest = (nstb < stall);
                prev_acc = avm_read && !avm_waitrequest;
                nstb++;
                last_stb = i;
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (rsp_valid) begin
                rsp_at = i;
                to = rsp_timeout;
                rd = rsp_rdata;
            end
        end
        if (rsp_at >= 0) delay = rsp_at - last_stb;
        @(posedge clk); #1;
        avm_waitrequest = 1'b0;
        if (rsp_valid || !cmd_ready || avm_read || avm_write) bus_err++;
        cmd_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int nstb, delay, bus_err, pulses, e_stb, e_delay;
        logic to, e_to;
        logic [31:0] rd, e_rd;
        logic wr;
        logic [3:0] addr;
        logic [31:0] wd, sd;
        int stall;

        vecs[0] = '{1'b1, 4'h1, 32'hA5A5_0001, 0, 32'h0,         1, 1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 4'h0, 32'h0,         3, 32'h0000_00FF, 4, 2, 1'b0, 32'h0000_00FF};
        vecs[2] = '{1'b0, 4'h2, 32'h0,         8, 32'h1234_5678, 8, 1, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 4'h3, 32'h0,         7, 32'hCAFE_F00D, 8, 2, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 4'h4, 32'h1111_2222, 7, 32'h0,         8, 1, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 4'h5, 32'h3333_4444, 8, 32'h0,         8, 1, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 4'hF, 32'h0,         0, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 4'hE, 32'h5555_6666, 20, 32'h0,        8, 1, 1'b1, 32'h0};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0;
        #23;
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_strobes", {30'h0, avm_read, avm_write}, 32'h0);
        check("rst_rsp", {30'h0, rsp_valid, rsp_timeout}, 32'h0);
        check("rst_addr", 32'(avm_address), 32'h0);
        check("rst_wdata", avm_writedata, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a stalled write.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 32'h0000_1234;
        avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("midrst_write_up", 32'(avm_write), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_write_drop", 32'(avm_write), 32'h0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("midrst_no_rsp", 32'(pulses), 32'h0);
        check("midrst_ready", 32'(cmd_ready), 32'h1);
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].stall, vecs[v].sdata,
                    bit'(v % 2), nstb, delay, to, rd, bus_err);
            check($sformatf("vec%0d_strobe_cycles", v), 32'(nstb), 32'(vecs[v].e_stb));
            check($sformatf("vec%0d_rsp_delay", v), 32'(delay), 32'(vecs[v].e_delay));
            check($sformatf("vec%0d_timeout", v), 32'(to), 32'(vecs[v].e_to));
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].e_rd);
            check($sformatf("vec%0d_bus_errors", v), 32'(bus_err), 32'h0);
        end

        for (int r = 0; r < 40; r++) begin
            wr    = 1'($urandom);
            addr  = 4'($urandom);
            wd    = $urandom;
            sd    = $urandom;
            stall = $urandom_range(0, 11);
            model(wr, stall, sd, e_stb, e_delay, e_to, e_rd);
            run_txn(wr, addr, wd, stall, sd, bit'($urandom_range(0, 1)),
                    nstb, delay, to, rd, bus_err);
            check($sformatf("rnd%0d_strobe_cycles", r), 32'(nstb), 32'(e_stb));
            check($sformatf("rnd%0d_rsp_delay", r), 32'(delay), 32'(e_delay));
            check($sformatf("rnd%0d_timeout", r), 32'(to), 32'(e_to));
            check($sformatf("rnd%0d_rdata", r), rd, e_rd);
            check($sformatf("rnd%0d_bus_errors", r), 32'(bus_err), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_pio_initiator.md
# avalon_pio_initiator

Avalon-MM initiator that turns single-word command requests into bus read/write cycles toward the `custom_pio` register slave, or any slave on the same Qsys-style interface, and returns one response per command. It drives the requester side of the interface that `custom_pio` responds to. It sits between control logic (sequencer or HPS bridge glue) and the PIO/register slaves of the video controller. One command is in flight at a time. Waitrequest and a fixed read latency are honoured, and a stalled slave is bounded by a timeout.

## Interface
- ADDR_W, 4, address width.
- DATA_W, 32, data width.
- READ_LATENCY, 1, slave read latency in cycles, 0..3. 0 means readdata is valid in the same cycle as read acceptance.
- TIMEOUT, 255, max stalled cycles with waitrequest high before abort. 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  qualifies rsp_valid: command aborted.
- avm_address  out  ADDR_W  bus address.
- avm_read  out  1  read strobe.
- avm_write  out  1  write strobe.
- avm_writedata  out  DATA_W  bus write data.
- avm_readdata  in  DATA_W  bus read data.
- avm_waitrequest  in  1  slave stall.

## Operation
- FSM states: IDLE, WR, RD, RD_LAT, RSP.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1, cmd_write, cmd_addr and cmd_wdata are registered.
  - Next state is WR if cmd_write=1, otherwise RD.
- WR:
  - avm_write=1, avm_address and avm_writedata hold the registered values.
  - The strobe is held while avm_waitrequest=1.
  - A cycle with avm_waitrequest=0 completes the write → RSP.
- RD:
  - avm_read=1, held while avm_waitrequest=1.
  - A cycle with avm_waitrequest=0 is the acceptance cycle.
  - If READ_LATENCY=0, avm_readdata is captured at that edge → RSP.
  - Otherwise → RD_LAT.
- RD_LAT:
  - Strobes low; a latency counter starts at 1.
  - avm_readdata is captured at the edge ending the READ_LATENCY-th cycle after the acceptance cycle → RSP.
- RSP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata = captured data (reads), 0 otherwise.
  - → IDLE.
  - There is no rsp_ready; the consumer must sample on the pulse.
- Timeout (WR/RD only):
  - A stall counter clears on entry to WR/RD and increments on each cycle with the strobe high and avm_waitrequest=1.
  - When the counter equals TIMEOUT, the strobe drops at the next edge → RSP with rsp_timeout=1 and rsp_rdata=0.
  - The counter width is ceil(log2(TIMEOUT+1)); it never wraps.
- cmd_valid outside IDLE is ignored; commands are not queued.
- avm_read and avm_write are never high together.
- avm_address and avm_writedata are stable while a strobe is high.
- Strobes are registered outputs, with no combinational path from cmd_* to avm_*.

## Timing
- Reset (asynchronous assert, synchronous deassert by the FSM on the next edge):
  - State → IDLE.
  - cmd_ready=1, avm_read=0, avm_write=0, rsp_valid=0, rsp_timeout=0.
  - avm_address, avm_writedata and rsp_rdata are 0.
- Reset mid-transaction drops the strobe immediately; no response is issued.
- Write, waitrequest=0:
  - Command accepted at edge 0.
  - avm_write high in cycle 1.
  - rsp_valid in cycle 2.
  - cmd_ready in cycle 3.
  - Throughput is 1 command per 3 cycles.
- Read, waitrequest=0, READ_LATENCY=1:
  - avm_read in cycle 1.
  - Data captured at the end of cycle 2.
  - rsp_valid in cycle 3.
- Each stalled cycle adds one cycle to either path.
- Timeout: with TIMEOUT=N and waitrequest held high, the strobe is high for exactly N cycles; rsp_valid+rsp_timeout follows in the next cycle.
- If waitrequest falls in the same cycle the counter reaches TIMEOUT, the transfer completes normally (rsp_timeout=0).

## Test plan
- Reset values:
  - Assert reset_n=0 for 100 ns mid-write with avm_write=1.
  - Required: avm_write=0 immediately, rsp_valid never pulses, cmd_ready=1 after release.
- Write, no stall:
  - cmd addr=1, wdata=0xA5A5_0001.
  - Required: avm_write=1 for 1 cycle with avm_address=1 and avm_writedata=0xA5A5_0001, then a single rsp_valid with rsp_rdata=0.
- Read with stall, READ_LATENCY=1:
  - addr=0, waitrequest high for 3 cycles, then slave returns 0x0000_00FF one cycle after acceptance.
  - Required: avm_read high for 4 cycles, rsp_valid with rsp_rdata=0xFF 2 cycles after the final read cycle.
- Timeout, TIMEOUT=8:
  - Hold waitrequest=1 on a read.
  - Required: avm_read high for exactly 8 cycles, then rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
- Timeout boundary:
  - Release waitrequest in the 8th stalled cycle.
  - Required: normal completion, rsp_timeout=0.
- Back-to-back and ignored commands:
  - Hold cmd_valid=1 with alternating write/read commands.
  - Required: one response per accepted command, in order, with no overlapping strobes.
  - cmd_valid pulses outside IDLE produce no extra bus cycles.
